// File: rtl/lzw_pkg.sv
// Shared LZW definitions: default dictionary geometry, clear-sequencer
// states and the bank-select helper used by the dictionary RAM.
package lzw_pkg;

    localparam int unsigned LZW_DATA_W    = 13;
    localparam int unsigned LZW_ADDR_W    = 12;
    localparam int unsigned LZW_BANK_BITS = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } dict_clr_state_t;

    function automatic logic [31:0] bank_of(
        input logic [31:0] addr,
        input int unsigned bank_bits
    );
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/lzw_dict_bank.sv
// One simple dual-port synchronous RAM bank with read-old-data
// behaviour on same-address collisions; the array has no reset.
module lzw_dict_bank #(
    parameter int unsigned DATA_W = 13,
    parameter int unsigned ROW_W  = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ROW_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ROW_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ROW_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lzw_dict_ram.sv
// Banked LZW dictionary RAM with separate read/write ports, optional
// write-first bypass and a hardware clear sweep after reset or clr.
module lzw_dict_ram
    import lzw_pkg::*;
#(
    parameter int unsigned       DATA_W    = LZW_DATA_W,
    parameter int unsigned       ADDR_W    = LZW_ADDR_W,
    parameter int unsigned       BANK_BITS = LZW_BANK_BITS,
    parameter logic [DATA_W-1:0] INIT_VAL  = '0,
    parameter bit                BYPASS    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid
);

    localparam int unsigned NUM_BANKS = 2**BANK_BITS;
    localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

    dict_clr_state_t state_q, state_d;
    logic [ROW_W-1:0]     cnt_q, cnt_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]    rd_hold_q, rd_hold_d;
    logic [BANK_BITS-1:0] rd_bank_q, rd_bank_d;
    logic                 byp_q, byp_d;
    logic [DATA_W-1:0]    byp_data_q, byp_data_d;

    logic                 clearing, acc_ok, wr_fire, rd_fire;
    logic [BANK_BITS-1:0] wr_bank, rd_bank;
    logic [ROW_W-1:0]     wr_row, rd_row;
    logic [NUM_BANKS-1:0] bank_we, bank_re;
    logic [ROW_W-1:0]     bank_waddr;
    logic [DATA_W-1:0]    bank_wdata;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    assign clearing = (state_q == CLEAR);
    assign busy     = clearing;
    // A clr pulse wins over any access sampled in the same cycle.
    assign acc_ok   = !clearing && !clr;
    assign wr_fire  = acc_ok && wr_en;
    assign rd_fire  = acc_ok && rd_en;

    assign wr_bank = BANK_BITS'(bank_of(32'(wr_addr), BANK_BITS));
    assign rd_bank = BANK_BITS'(bank_of(32'(rd_addr), BANK_BITS));
    assign wr_row  = wr_addr[ADDR_W-1:BANK_BITS];
    assign rd_row  = rd_addr[ADDR_W-1:BANK_BITS];

    assign bank_waddr = clearing ? cnt_q : wr_row;
    assign bank_wdata = clearing ? INIT_VAL : wr_data;

    always_comb begin
        bank_we = '0;
        bank_re = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_we[b] = clearing || (wr_fire && (wr_bank == BANK_BITS'(b)));
            bank_re[b] = rd_fire && (rd_bank == BANK_BITS'(b));
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        lzw_dict_bank #(
            .DATA_W (DATA_W),
            .ROW_W  (ROW_W)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[g]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (bank_re[g]),
            .raddr (rd_row),
            .rdata (bank_rdata[g])
        );
    end

    always_comb begin
        rd_data = rd_hold_q;
        if (rd_valid_q) begin
            rd_data = byp_q ? byp_data_q : bank_rdata[rd_bank_q];
        end
    end

    assign rd_valid = rd_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_fire;
        rd_hold_d  = rd_data;
        rd_bank_d  = rd_fire ? rd_bank : rd_bank_q;
        byp_d      = BYPASS && rd_fire && wr_fire && (rd_addr == wr_addr);
        byp_data_d = wr_fire ? wr_data : byp_data_q;
        unique case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == ROW_MAX) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + ROW_W'(1);
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_hold_q  <= '0;
            rd_bank_q  <= '0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            rd_hold_q  <= rd_hold_d;
            rd_bank_q  <= rd_bank_d;
            byp_q      <= byp_d;
            byp_data_q <= byp_data_d;
        end
    end

endmodule

// File: tb/tb_lzw_dict_ram.sv
// Directed, table-driven bench for lzw_dict_ram in bypass, no-bypass
// and reduced-geometry configurations.
module tb_lzw_dict_ram;

    typedef struct {
        logic        we;
        logic [11:0] wa;
        logic [12:0] wd;
        logic        re;
        logic [11:0] ra;
        logic        ev;
        logic [12:0] ed;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst = 1'b1;
    logic        clr_a = 1'b0, busy_a, we_a = 1'b0, re_a = 1'b0, rv_a;
    logic [11:0] wa_a = '0, ra_a = '0;
    logic [12:0] wd_a = '0, rd_a;

    logic        clr_b = 1'b0, busy_b, we_b = 1'b0, re_b = 1'b0, rv_b;
    logic [11:0] wa_b = '0, ra_b = '0;
    logic [12:0] wd_b = '0, rd_b;

    logic        rst_c = 1'b1;
    logic        clr_c = 1'b0, busy_c, we_c = 1'b0, re_c = 1'b0, rv_c;
    logic [9:0]  wa_c = '0, ra_c = '0;
    logic [8:0]  wd_c = '0, rd_c;

    lzw_dict_ram #(.BYPASS(1'b1)) u_a (
        .clk(clk), .rst(rst), .clr(clr_a), .busy(busy_a),
        .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a),
        .rd_en(re_a), .rd_addr(ra_a), .rd_data(rd_a), .rd_valid(rv_a)
    );

    lzw_dict_ram #(.BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .clr(clr_b), .busy(busy_b),
        .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b),
        .rd_en(re_b), .rd_addr(ra_b), .rd_data(rd_b), .rd_valid(rv_b)
    );

    lzw_dict_ram #(.DATA_W(9), .ADDR_W(10), .BANK_BITS(3)) u_c (
        .clk(clk), .rst(rst_c), .clr(clr_c), .busy(busy_c),
        .wr_en(we_c), .wr_addr(wa_c), .wr_data(wd_c),
        .rd_en(re_c), .rd_addr(ra_c), .rd_data(rd_c), .rd_valid(rv_c)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [11:0] wa,
                                input logic [12:0] wd, input logic re,
                                input logic [11:0] ra, input logic ev,
                                input logic [12:0] ed);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd;
        v.re = re; v.ra = ra; v.ev = ev; v.ed = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input vec_t v, input int idx);
        we_a = v.we; wa_a = v.wa; wd_a = v.wd;
        re_a = v.re; ra_a = v.ra;
        tick();
        check($sformatf("a_valid[%0d]", idx), 32'(rv_a), 32'(v.ev));
        check($sformatf("a_data[%0d]", idx), 32'(rd_a), 32'(v.ed));
        we_a = 1'b0; re_a = 1'b0;
    endtask

    task automatic step_b(input vec_t v, input int idx);
        we_b = v.we; wa_b = v.wa; wd_b = v.wd;
        re_b = v.re; ra_b = v.ra;
        tick();
        check($sformatf("b_valid[%0d]", idx), 32'(rv_b), 32'(v.ev));
        check($sformatf("b_data[%0d]", idx), 32'(rd_b), 32'(v.ed));
        we_b = 1'b0; re_b = 1'b0;
    endtask

    task automatic step_c(input logic we, input logic [9:0] wa,
                          input logic [8:0] wd, input logic re,
                          input logic [9:0] ra, input logic ev,
                          input logic [8:0] ed, input string name);
        we_c = we; wa_c = wa; wd_c = wd; re_c = re; ra_c = ra;
        tick();
        check({name, "_valid"}, 32'(rv_c), 32'(ev));
        check({name, "_data"}, 32'(rd_c), 32'(ed));
        we_c = 1'b0; re_c = 1'b0;
    endtask

    task automatic busy_len_a(output int n);
        n = 0;
        while (busy_a && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_clr_a();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
    endtask

    vec_t va[$];
    vec_t vb[$];
    int   n;

    initial begin
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h000, 1, 13'h0000));
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h7FF, 1, 13'h0000));
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'hFFF, 1, 13'h0000));
        va.push_back(mk(1, 12'h005, 13'h1ABC, 0, 12'h000, 0, 13'h0000));
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h005, 1, 13'h1ABC));
        for (int i = 0; i < 10; i++)
            va.push_back(mk(0, 12'h000, 13'h0000, 0, 12'h005, 0, 13'h1ABC));
        for (int i = 0; i < 4; i++)
            va.push_back(mk(1, 12'(8 + i), 13'(1 + i), 0, 12'h000,
                            0, 13'h1ABC));
        for (int i = 0; i < 4; i++)
            va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'(11 - i),
                            1, 13'(4 - i)));
        va.push_back(mk(1, 12'h00C, 13'h00AA, 1, 12'h008, 1, 13'h0001));
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h00C, 1, 13'h00AA));
        va.push_back(mk(1, 12'h123, 13'h00AA, 0, 12'h000, 0, 13'h00AA));
        va.push_back(mk(1, 12'h123, 13'h0155, 1, 12'h123, 1, 13'h0155));
        va.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h123, 1, 13'h0155));

        vb.push_back(mk(1, 12'h123, 13'h00AA, 0, 12'h000, 0, 13'h0000));
        vb.push_back(mk(1, 12'h123, 13'h0155, 1, 12'h123, 1, 13'h00AA));
        vb.push_back(mk(0, 12'h000, 13'h0000, 1, 12'h123, 1, 13'h0155));

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_data", 32'(rd_a), 32'h0);
        check("reset_rd_valid", 32'(rv_a), 32'h0);
        check("reset_busy", 32'(busy_a), 32'h1);
        rst = 1'b0;
        busy_len_a(n);
        check("reset_clear_len", 32'(n), 32'd1024);
        check("b_idle_after_clear", 32'(busy_b), 32'h0);

        foreach (va[i]) step_a(va[i], i);
        foreach (vb[i]) step_b(vb[i], i);

        pulse_clr_a();
        repeat (200) tick();
        check("pre_rst_rd_data", 32'(rd_a), 32'h155);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_rd_data", 32'(rd_a), 32'h0);
        check("rst_mid_busy", 32'(busy_a), 32'h1);
        busy_len_a(n);
        check("rst_mid_clear_len", 32'(n), 32'd1024);

        pulse_clr_a();
        check("clr_busy", 32'(busy_a), 32'h1);
        repeat (3) tick();
        step_a(mk(1, 12'h004, 13'h1FFF, 1, 12'h004, 0, 13'h0000), 100);
        busy_len_a(n);
        check("clr_len", 32'(n), 32'd1020);
        step_a(mk(0, 12'h000, 13'h0000, 1, 12'h004, 1, 13'h0000), 101);

        step_a(mk(1, 12'h004, 13'h1FFF, 0, 12'h000, 0, 13'h0000), 102);
        pulse_clr_a();
        repeat (500) tick();
        check("clr500_busy", 32'(busy_a), 32'h1);
        pulse_clr_a();
        busy_len_a(n);
        check("clr500_restart_len", 32'(n), 32'd1024);
        step_a(mk(0, 12'h000, 13'h0000, 1, 12'h004, 1, 13'h0000), 103);

        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        n = 0;
        while (busy_c && n < 1000) begin
            tick();
            n++;
        end
        check("c_clear_len", 32'(n), 32'd128);
        step_c(0, 10'h000, 9'h000, 1, 10'h3FF, 1, 9'h000, "c_rd_init");
        step_c(1, 10'h005, 9'h1A5, 0, 10'h000, 0, 9'h000, "c_wr5");
        step_c(1, 10'h3FF, 9'h0FF, 1, 10'h005, 1, 9'h1A5, "c_rd5");
        step_c(1, 10'h00D, 9'h133, 1, 10'h3FF, 1, 9'h0FF, "c_rd3ff");
        step_c(0, 10'h000, 9'h000, 1, 10'h00D, 1, 9'h133, "c_rd13");
        step_c(0, 10'h000, 9'h000, 0, 10'h000, 0, 9'h133, "c_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
